// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter fetch/execute sequencer.
package pc_seq_pkg;

    // Width of the PC, memory address and instruction word.
    localparam int WORD_W = 16;

    // Default number of FETCH cycles allowed without a memory ack.
    localparam int TIMEOUT_DEF = 15;

    // Sequencer states; the encoding is fixed so debug tools can decode it.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/pc_seq_timer.sv
// Fetch timer: loadable up-counter with clear and enable. o_term flags the
// enabled cycle whose edge carries the count to TIMEOUT.
module pc_seq_timer #(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_term
);

    localparam logic [TMR_W-1:0] LAST_BEFORE_TERM = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] r_count;

    // Counter register: clear wins over load, load wins over increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal flag: this enabled cycle brings the count up to TIMEOUT.
    always_comb begin
        o_term = i_en && !i_clr && !i_load && (r_count == LAST_BEFORE_TERM);
    end

endmodule

// File: rtl/pc_seq.sv
// Fetch/execute sequencer for a 16-bit program counter. Fetches the word at
// pc_value, hands it to the execute unit, then applies exactly one PC update
// (inc, add or sub) per retired instruction.
//
// Handshakes: mem_req is held high in FETCH until a cycle with mem_ack=1,
// which transfers mem_rdata; instr_valid is held high in EXEC until a cycle
// with exec_done=1, which transfers the branch/halt decision. Acks arriving
// outside those states carry no transfer and are ignored.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TMR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [WORD_W-1:0] pc_value,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              br_take,
    input  logic              br_back,
    input  logic [WORD_W-1:0] br_offset,
    input  logic              halt_req,
    output logic              pc_inc,
    output logic              pc_add,
    output logic              pc_sub,
    output logic [WORD_W-1:0] pc_offset,
    output logic              halted,
    output logic              fetch_err,
    output logic [WORD_W-1:0] instr_count,
    output state_t            dbg_state
);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_count;
    logic              r_fetch_err;
    logic              r_br_take;
    logic              r_br_back;
    logic [WORD_W-1:0] r_br_offset;
    logic              w_in_fetch;
    logic              w_fetch_hit;
    logic              w_exec_hit;
    logic              w_tmr_term;

    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_fetch_hit = w_in_fetch && mem_ack;
    assign w_exec_hit  = (r_state == ST_EXEC) && exec_done;

    // Timer only runs during an un-acked fetch; it idles at zero elsewhere.
    pc_seq_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_clr      (!w_in_fetch || mem_ack),
        .i_en       (w_in_fetch && !mem_ack),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_term     (w_tmr_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an ack on the timeout cycle is checked first so it wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack)         w_state_next = ST_EXEC;
                else if (w_tmr_term) w_state_next = ST_HALT;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    w_state_next = halt_req ? ST_HALT : ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode; the registered branch decision selects one strobe.
    always_comb begin
        mem_req     = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        pc_inc      = 1'b0;
        pc_add      = 1'b0;
        pc_sub      = 1'b0;
        pc_offset   = '0;
        halted      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
            end
            ST_UPDATE: begin
                if (!r_br_take) begin
                    pc_inc = 1'b1;
                end else begin
                    pc_add    = !r_br_back;
                    pc_sub    = r_br_back;
                    pc_offset = r_br_offset;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Instruction latch on the accepted fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= '0;
        end else if (w_fetch_hit) begin
            r_instr <= mem_rdata;
        end
    end

    // Branch decision captured when the execute unit completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_take   <= 1'b0;
            r_br_back   <= 1'b0;
            r_br_offset <= '0;
        end else if (w_exec_hit) begin
            r_br_take   <= br_take;
            r_br_back   <= br_back;
            r_br_offset <= br_offset;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_state == ST_UPDATE) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Sticky fetch error: set when the timer expires with no ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_err <= 1'b0;
        end else if (w_in_fetch && !mem_ack && w_tmr_term) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign instr       = r_instr;
    assign instr_count = r_count;
    assign fetch_err   = r_fetch_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a behavioural PC, memory and execute driver, and
// a monitor that pops expected fetch addresses and PC updates from queues.
module tb_pc_seq;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [15:0] pc_value;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        br_take = 1'b0;
    logic        br_back = 1'b0;
    logic [15:0] br_offset = '0;
    logic        halt_req = 1'b0;
    logic        pc_inc;
    logic        pc_add;
    logic        pc_sub;
    logic [15:0] pc_offset;
    logic        halted;
    logic        fetch_err;
    logic [15:0] instr_count;
    state_t      dbg_state;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_addr_q[$];
    logic [34:0] exp_upd_q[$];

    pc_seq #(.TIMEOUT(15), .TMR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_value    (pc_value),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .br_take     (br_take),
        .br_back     (br_back),
        .br_offset   (br_offset),
        .halt_req    (halt_req),
        .pc_inc      (pc_inc),
        .pc_add      (pc_add),
        .pc_sub      (pc_sub),
        .pc_offset   (pc_offset),
        .halted      (halted),
        .fetch_err   (fetch_err),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Behavioural PC register sharing clk/reset with the sequencer.
    logic [15:0] pc_q;
    always @(posedge clk) begin
        if (reset)       pc_q <= 16'h0000;
        else if (pc_inc) pc_q <= pc_q + 16'h0001;
        else if (pc_add) pc_q <= pc_q + pc_offset;
        else if (pc_sub) pc_q <= pc_q - pc_offset;
    end
    assign pc_value = pc_q;

    task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] upd(input logic inc, input logic add, input logic sub,
                                        input logic [15:0] off, input logic [15:0] ins);
        return {inc, add, sub, off, ins};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on accepted fetches and on PC update strobes.
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [34:0] eu;
        if (mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) begin
                check("fetch_unexpected", 35'(mem_addr), 35'h7FFFFFFFF);
            end else begin
                ea = exp_addr_q.pop_front();
                check("fetch_addr", 35'(mem_addr), 35'(ea));
            end
        end
        if (pc_inc || pc_add || pc_sub) begin
            check("strobe_onehot", 35'(int'(pc_inc) + int'(pc_add) + int'(pc_sub)), 35'd1);
            if (exp_upd_q.size() == 0) begin
                check("update_unexpected", upd(pc_inc, pc_add, pc_sub, pc_offset, instr), 35'h0);
            end else begin
                eu = exp_upd_q.pop_front();
                check("pc_update", upd(pc_inc, pc_add, pc_sub, pc_offset, instr), eu);
            end
        end else begin
            check("offset_idle_zero", 35'(pc_offset), 35'h0);
        end
    end

    // Driver: wait for a fetch, optionally stall, then ack with a word.
    task automatic do_fetch(input logic [15:0] word, input logic [15:0] exp_addr, input int stall);
        int n = 0;
        while (!mem_req && n < 50) begin
            tick();
            n++;
        end
        if (!mem_req) begin
            check("fetch_wait_timeout", 35'(mem_req), 35'h1);
            return;
        end
        repeat (stall) tick();
        exp_addr_q.push_back(exp_addr);
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("instr_latched", 35'(instr), 35'(word));
        check("instr_valid", 35'(instr_valid), 35'h1);
    endtask

    // Driver: complete the current instruction with a branch/halt decision.
    task automatic do_exec(input logic take, input logic back, input logic [15:0] off,
                           input logic hlt, input logic [34:0] exp_upd);
        int n = 0;
        while (!instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!instr_valid) begin
            check("exec_wait_timeout", 35'(instr_valid), 35'h1);
            return;
        end
        if (!hlt) exp_upd_q.push_back(exp_upd);
        exec_done = 1'b1;
        br_take   = take;
        br_back   = back;
        br_offset = off;
        halt_req  = hlt;
        tick();
        exec_done = 1'b0;
        br_take   = 1'b0;
        br_back   = 1'b0;
        br_offset = '0;
        halt_req  = 1'b0;
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", 35'(dbg_state), 35'(ST_IDLE));
        check("rst_outputs", 35'({mem_req, instr_valid, pc_inc, pc_add, pc_sub, halted, fetch_err}), 35'h0);
        check("rst_instr", 35'(instr), 35'h0);
        check("rst_count", 35'(instr_count), 35'h0);
        check("rst_addr", 35'(mem_addr), 35'h0);

        // Straight-line increments: PC 0 -> 4
        run = 1'b1;
        do_fetch(16'h1234, 16'h0000, 0);
        do_exec(1'b0, 1'b0, 16'h0000, 1'b0, upd(1, 0, 0, 16'h0000, 16'h1234));
        for (int i = 1; i < 4; i++) begin
            do_fetch(16'h1000 + 16'(i), 16'(i), 0);
            if (i == 1) check("count_after_first", 35'(instr_count), 35'h1);
            do_exec(1'b0, 1'b0, 16'h0000, 1'b0, upd(1, 0, 0, 16'h0000, 16'h1000 + 16'(i)));
        end

        // Forward branch from 0x0004 by 0x0010
        do_fetch(16'hA004, 16'h0004, 0);
        check("count_before_fwd", 35'(instr_count), 35'h4);
        do_exec(1'b1, 1'b0, 16'h0010, 1'b0, upd(0, 1, 0, 16'h0010, 16'hA004));

        // Backward branch from 0x0014 by 0x0014; ack on the 15th FETCH cycle
        do_fetch(16'hB014, 16'h0014, 14);
        check("late_ack_no_err", 35'({fetch_err, halted}), 35'h0);
        do_exec(1'b1, 1'b1, 16'h0014, 1'b0, upd(0, 0, 1, 16'h0014, 16'hB014));

        // Halt request with a taken branch: no update, count unchanged
        do_fetch(16'h5555, 16'h0000, 0);
        check("count_before_halt", 35'(instr_count), 35'h6);
        do_exec(1'b1, 1'b0, 16'h0007, 1'b1, 35'h0);
        check("halt_state", 35'(halted), 35'h1);
        repeat (3) tick();
        check("halt_hold", 35'({halted, mem_req, instr_valid}), 35'h4);
        check("halt_pc", 35'(pc_value), 35'h0);
        check("halt_count", 35'(instr_count), 35'h6);

        // Fetch timeout with no ack at all
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("to_first_addr", 35'(mem_addr), 35'h0);
        check("to_fetching", 35'(mem_req), 35'h1);
        repeat (14) tick();
        check("to_cycle15", 35'({mem_req, fetch_err, halted}), 35'h4);
        tick();
        check("to_expired", 35'({mem_req, fetch_err, halted}), 35'h3);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            tick();
            check("to_hold", 35'({mem_req, fetch_err, halted}), 35'h3);
        end
        run = 1'b1;

        // Reset during FETCH with a simultaneous ack
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("pre_rst_fetch", 35'(dbg_state), 35'(ST_FETCH));
        exp_addr_q.push_back(16'h0000);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("rst_ack_state", 35'(dbg_state), 35'(ST_IDLE));
        check("rst_ack_instr", 35'(instr), 35'h0);
        check("rst_ack_err", 35'({fetch_err, halted, mem_req}), 35'h0);
        tick();
        check("rst_refetch_addr", 35'({mem_req, mem_addr}), 35'h10000);

        // Zero-offset branch leaves the PC in place, then a plain increment
        do_fetch(16'h4321, 16'h0000, 0);
        do_exec(1'b1, 1'b0, 16'h0000, 1'b0, upd(0, 1, 0, 16'h0000, 16'h4321));
        do_fetch(16'h0F0F, 16'h0000, 0);
        do_exec(1'b0, 1'b0, 16'h0000, 1'b0, upd(1, 0, 0, 16'h0000, 16'h0F0F));
        run = 1'b0;
        tick();
        check("final_count", 35'(instr_count), 35'h2);
        check("final_pc", 35'(pc_value), 35'h1);
        check("final_idle", 35'(dbg_state), 35'(ST_IDLE));
        repeat (2) tick();
        check("addr_q_empty", 35'(exp_addr_q.size()), 35'h0);
        check("upd_q_empty", 35'(exp_upd_q.size()), 35'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
